spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
// - SPI target (slave) for the far end of the SoC SPI controller: sclk/mosi/ssn in, miso out.
// - Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
// - All SPI inputs are oversampled in the clk domain. There is no second clock domain.
// - Host side is a one-entry TX buffer and a one-entry RX holding register, with valid/ack.
// - Used as the loopback partner and companion peripheral for SoC bring-up and test.
// PARAMETERS
// - WIDTH        8      frame length in bits
// - SYNC_STAGES  2      flip-flop synchronizer depth on sclk, mosi and ssn (>=2)
// - IDLE_WORD    8'hFF  word shifted out when the TX buffer is empty at frame start
// PORTS
// - clk       in   1      system clock. sclk must be at most clk/4.
// - rst_n     in   1      asynchronous reset, active-low
// - sclk      in   1      SPI clock from the controller
// - mosi      in   1      controller-to-target data
// - ssn       in   1      target select, active-low
// - miso      out  1      target-to-controller data; 0 when not selected
// - miso_oe   out  1      1 while ssn (synchronized) is low
// - tx_data   in   WIDTH  word for the next frame
// - tx_load   in   1      1-cycle strobe; writes tx_data into the TX buffer
// - tx_ready  out  1      TX buffer empty
// - rx_data   out  WIDTH  last complete received frame
// - rx_valid  out  1      rx_data holds an unread frame
// - rx_ack    in   1      1-cycle strobe; clears rx_valid and overrun
// - overrun   out  1      sticky: a frame completed while rx_valid was already 1
// - busy      out  1      a frame is in progress (state SHIFT)
// BEHAVIOUR
// - Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, busy=0.
//   Reset also clears the shift register, bit counter and synchronizers (synchronized ssn resets to 1).
// - Edge detection uses the synchronized signals only.
//   - sr: sclk rise. sf: sclk fall. sa: ssn fall. sd: ssn rise.
// - FSM IDLE:
//   - On sa go to SHIFT and clear bit_cnt.
//   - Load shreg from the TX buffer if it is full; the buffer then empties and tx_ready=1 next cycle.
//   - Otherwise load shreg from IDLE_WORD.
// - FSM SHIFT:
//   - miso = shreg[WIDTH-1] continuously.
//   - On sr: capture mosi into rxsh (shifting left) and increment bit_cnt.
//   - On sf: shift shreg left by one, unless bit_cnt==WIDTH.
//   - When bit_cnt reaches WIDTH on an sr: rx_data <= rxsh, rx_valid <= 1.
//     overrun <= 1 if rx_valid was already 1 and rx_ack is not asserted in that cycle.
//   - On the sf after the last bit (bit_cnt==WIDTH): reload shreg as in IDLE and clear bit_cnt.
//     This supports back-to-back frames with ssn held low.
//   - On sd: go to IDLE. A partial frame is discarded (no rx_valid, rx_data unchanged).
//     A word loaded into shreg is not returned to the TX buffer.
//   - sd has priority over sr/sf in the same cycle.
// - Latencies:
//   - miso becomes valid SYNC_STAGES+2 clk after ssn falls.
//     The controller must leave at least that gap before the first sclk rise.
//   - rx_valid rises SYNC_STAGES+1 clk after the final sclk rise.
// - Host TX side:
//   - tx_load with tx_ready=1 fills the buffer; tx_ready=0 next cycle.
//   - tx_load with tx_ready=0 is ignored; the old word is kept.
//   - tx_load in the same cycle as a buffer reload: the reload takes the old word, then the new word is stored.
// - Host RX side:
//   - rx_ack clears rx_valid and overrun next cycle.
//   - rx_ack coinciding with frame completion: rx_valid stays 1 with the new data, and overrun is not set.
// - Asserting rst_n low mid-frame returns everything to reset values immediately.
// STRUCTURE
// - Shared package: WIDTH default, state encoding (IDLE=1'b0, SHIFT=1'b1), IDLE_WORD default.
// - Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
//   Instantiated for sclk and ssn; mosi uses the synchronizer only.
// - The rest stays flat: FSM, bit counter, shreg, rxsh and the host buffers.
// TESTING
// - Reset: rst_n=0 -> miso=0, miso_oe=0, tx_ready=1, rx_valid=0, overrun=0; hold for 5 clks.
// - Single frame: load 8'hA5, then the controller sends 8'h3C at clk/8.
//   -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1; tx_ready=1 after ssn fall.
// - Empty TX: no tx_load, controller sends 8'h00 -> miso shifts 8'hFF; rx_data=8'h00.
// - Back-to-back frames with ssn held low, no rx_ack: load 8'h11 then 8'h22, controller sends 8'h01 then 8'h02.
//   -> miso returns 8'h11, 8'h22; rx_data=8'h02, overrun=1.
//   -> rx_ack clears both flags.
// - Abort: ssn rises after 5 sclk edges -> rx_valid stays 0, rx_data unchanged, busy=0.
//   The next full frame with 8'h5A is received correctly.
// - Simultaneous events:
//   - rx_ack on the completion cycle -> rx_valid=1, overrun=0.
//   - tx_load while tx_ready=0 -> buffer unchanged.
//   - rst_n pulse mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_target_pkg
//  Description : Shared definitions for the SPI target: default frame width,
//                default idle word and the FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_target_pkg;

  localparam int SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] SPI_IDLE_WORD = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous input, plus
//                single-cycle rise/fall pulses derived from the synchronized
//                level.
//  Ports       : clk, rst_n   system clock, async active-low reset
//                din          asynchronous input
//                dout         synchronized level
//                rise, fall   one-clk pulses on a synchronized 0->1 / 1->0
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign dout = r_sync[SYNC_STAGES-1];
  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : spi_target
//  Description : SPI mode-0 target, MSB first, full duplex. All SPI pins are
//                oversampled in the clk domain. Host side has a one-entry TX
//                buffer and a one-entry RX holding register.
//  Ports       : clk, rst_n          system clock, async active-low reset
//                sclk, mosi, ssn     SPI pins from the controller
//                miso, miso_oe       SPI data out and its output enable
//                tx_data, tx_load    host write into the TX buffer
//                tx_ready            TX buffer empty
//                rx_data, rx_valid   last received frame and its valid flag
//                rx_ack              host read acknowledge
//                overrun             sticky: frame completed over unread data
//                busy                frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module spi_target
  import spi_target_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD   = SPI_IDLE_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ssn,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             overrun,
  output logic             busy
);

  localparam int               CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_PEN  = CNT_W'(WIDTH - 1);

  // Synchronized pins and edge pulses
  logic w_unused_sclk_lvl;
  logic w_sclk_rise, w_sclk_fall;
  logic w_ssn_s, w_ssn_rise, w_ssn_fall;
  logic w_mosi_s;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .dout  (w_unused_sclk_lvl),
    .rise  (w_sclk_rise),
    .fall  (w_sclk_fall)
  );

  // ssn idles high, so its synchronizer resets to 1 to avoid a false select.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync_ssn (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ssn),
    .dout  (w_ssn_s),
    .rise  (w_ssn_rise),
    .fall  (w_ssn_fall)
  );

  // mosi goes through the same depth so it stays aligned with the sclk pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // State and datapath registers
  spi_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, r_rxsh, r_tx_buf, r_rx_data;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_tx_full, r_rx_valid, r_overrun, r_miso;

  logic w_active, w_capture, w_done, w_shift, w_reload, w_tx_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Deselect wins over any sclk edge seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    w_shift     = 1'b0;
    w_reload    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ssn_fall) begin
          w_state_nxt = ST_SHIFT;
          w_reload    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_ssn_rise) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_active  = 1'b1;
          w_capture = w_sclk_rise && (r_bit_cnt != C_CNT_LAST);
          w_done    = w_capture && (r_bit_cnt == C_CNT_PEN);
          w_shift   = w_sclk_fall && (r_bit_cnt != C_CNT_LAST);
          // Falling edge after the last bit primes the next back-to-back frame.
          w_reload  = w_sclk_fall && (r_bit_cnt == C_CNT_LAST);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A load coinciding with a reload is accepted: the reload reads the old word.
  assign w_tx_accept = tx_load && (!r_tx_full || w_reload);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_rxsh     <= '0;
      r_bit_cnt  <= '0;
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      if (w_reload) begin
        r_shreg   <= r_tx_full ? r_tx_buf : IDLE_WORD;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
      end

      if (w_capture) begin
        r_rxsh    <= {r_rxsh[WIDTH-2:0], w_mosi_s};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end

      if (w_tx_accept) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_reload) begin
        r_tx_full <= 1'b0;
      end

      if (w_done) begin
        r_rx_data  <= {r_rxsh[WIDTH-2:0], w_mosi_s};
        r_rx_valid <= 1'b1;
        if (rx_ack)          r_overrun <= 1'b0;
        else if (r_rx_valid) r_overrun <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end

      r_miso <= (r_state == ST_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = ~w_ssn_s;
  assign tx_ready = ~r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;
  assign busy     = (r_state == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_target
//  Description : Self-checking bench for spi_target. A behavioural controller
//                drives sclk/mosi/ssn at clk/8; a word-level model tracks the
//                host-visible state and is compared every cycle outside frames.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, ssn = 1'b1;
  logic       miso, miso_oe, tx_ready, rx_valid, overrun, busy;
  logic       tx_load = 1'b0, rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_target #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .IDLE_WORD   (8'hFF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .ssn      (ssn),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .overrun  (overrun),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Word-level model of the host-visible state
  logic [7:0] m_tx_word  = 8'h00;
  logic [7:0] m_rx_data  = 8'h00;
  bit         m_tx_full  = 1'b0;
  bit         m_rx_valid = 1'b0;
  bit         m_overrun  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_start();
    logic [7:0] w;
    w = m_tx_full ? m_tx_word : 8'hFF;
    m_tx_full = 1'b0;
    return w;
  endfunction

  function automatic void model_end(input logic [7:0] mo, input bit acked);
    if (acked)           m_overrun = 1'b0;
    else if (m_rx_valid) m_overrun = 1'b1;
    m_rx_valid = 1'b1;
    m_rx_data  = mo;
  endfunction

  function automatic void model_reset();
    m_tx_word = 8'h00; m_rx_data = 8'h00;
    m_tx_full = 1'b0; m_rx_valid = 1'b0; m_overrun = 1'b0;
  endfunction

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    if (!m_tx_full) begin
      m_tx_word = d;
      m_tx_full = 1'b1;
    end
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    m_rx_valid = 1'b0;
    m_overrun  = 1'b0;
    tick(1);
    rx_ack = 1'b0;
  endtask

  // Every-cycle comparison against the model while no frame is in flight.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("cmp_rx_data",  32'(rx_data),  32'(m_rx_data));
      check("cmp_rx_valid", 32'(rx_valid), 32'(m_rx_valid));
      check("cmp_overrun",  32'(overrun),  32'(m_overrun));
      check("cmp_tx_ready", 32'(tx_ready), 32'(!m_tx_full));
      check("cmp_busy",     32'(busy),     0);
      check("cmp_miso_oe",  32'(miso_oe),  0);
      check("cmp_miso",     32'(miso),     0);
    end
  end

  // One 8-bit transfer, mode 0: data set after the fall, sampled at the rise.
  // mode 1 checks rx_valid latency, mode 2 pulses rx_ack on the completion cycle.
  task automatic xfer(input logic [7:0] mo, input int mode, output logic [7:0] so);
    so = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      tick(4);
      so[i] = miso;
      sclk = 1'b1;
      if (i == 0 && mode == 1) begin
        tick(2);
        check("rx_valid_lat_early", 32'(rx_valid), 0);
        tick(1);
        check("rx_valid_lat_on", 32'(rx_valid), 1);
        tick(1);
      end else if (i == 0 && mode == 2) begin
        tick(2);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] mo, input int mode, input logic [7:0] lit_miso,
                       input string tag);
    logic [7:0] e_mi, so;
    chk_en = 1'b0;
    ssn = 1'b0;
    e_mi = model_start();
    if (mode == 1) begin
      tick(3);
      check({tag, "_miso_lat_early"}, 32'(miso), 0);
      tick(1);
      check({tag, "_miso_lat_on"}, 32'(miso), 32'(lit_miso[7]));
      check({tag, "_tx_ready_sel"}, 32'(tx_ready), 1);
      check({tag, "_busy_sel"}, 32'(busy), 1);
      check({tag, "_miso_oe_sel"}, 32'(miso_oe), 1);
    end
    xfer(mo, mode, so);
    model_end(mo, mode == 2);
    void'(model_start());  // final fall with ssn low reloads from the buffer
    check({tag, "_miso_model"}, 32'(so), 32'(e_mi));
    check({tag, "_miso_lit"}, 32'(so), 32'(lit_miso));
    tick(4);
    ssn = 1'b1;
    tick(6);
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e1, e2, s1, s2;

    // Reset
    chk_en = 1'b1;
    tick(5);
    check("rst_miso",     32'(miso),     0);
    check("rst_miso_oe",  32'(miso_oe),  0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_overrun",  32'(overrun),  0);
    check("rst_rx_data",  32'(rx_data),  0);
    check("rst_busy",     32'(busy),     0);
    rst_n = 1'b1;
    tick(3);

    // Single frame: target sends A5, controller sends 3C
    load(8'hA5);
    check("single_tx_ready_full", 32'(tx_ready), 0);
    frame(8'h3C, 1, 8'hA5, "single");
    check("single_rx_data", 32'(rx_data), 'h3C);
    check("single_rx_valid", 32'(rx_valid), 1);
    ack();
    tick(2);

    // Empty TX buffer shifts the idle word
    frame(8'h00, 0, 8'hFF, "empty_tx");
    check("empty_rx_data", 32'(rx_data), 'h00);
    check("empty_rx_valid", 32'(rx_valid), 1);
    ack();
    tick(2);

    // Back-to-back frames with ssn held low and no ack in between
    load(8'h11);
    chk_en = 1'b0;
    ssn = 1'b0;
    e1 = model_start();
    tick(4);
    load(8'h22);
    xfer(8'h01, 0, s1);
    model_end(8'h01, 1'b0);
    e2 = model_start();
    xfer(8'h02, 0, s2);
    model_end(8'h02, 1'b0);
    void'(model_start());
    check("b2b_miso1_model", 32'(s1), 32'(e1));
    check("b2b_miso1_lit", 32'(s1), 'h11);
    check("b2b_miso2_model", 32'(s2), 32'(e2));
    check("b2b_miso2_lit", 32'(s2), 'h22);
    tick(4);
    ssn = 1'b1;
    tick(6);
    chk_en = 1'b1;
    check("b2b_rx_data", 32'(rx_data), 'h02);
    check("b2b_overrun", 32'(overrun), 1);
    check("b2b_rx_valid", 32'(rx_valid), 1);
    ack();
    check("b2b_ack_rx_valid", 32'(rx_valid), 0);
    check("b2b_ack_overrun", 32'(overrun), 0);
    tick(2);

    // Abort after 5 sclk edges
    chk_en = 1'b0;
    ssn = 1'b0;
    void'(model_start());
    mosi = 1'b1;
    tick(4); sclk = 1'b1;
    tick(4); sclk = 1'b0;
    tick(4); sclk = 1'b1;
    tick(4); sclk = 1'b0;
    tick(4); sclk = 1'b1;
    tick(4); ssn = 1'b1;
    tick(4); sclk = 1'b0;
    tick(6);
    check("abort_rx_valid", 32'(rx_valid), 0);
    check("abort_rx_data", 32'(rx_data), 'h02);
    check("abort_busy", 32'(busy), 0);
    chk_en = 1'b1;
    frame(8'h5A, 0, 8'hFF, "after_abort");
    check("after_abort_rx_data", 32'(rx_data), 'h5A);

    // rx_ack on the completion cycle while rx_valid is already set
    frame(8'hA3, 2, 8'hFF, "ack_coinc");
    check("ack_coinc_rx_valid", 32'(rx_valid), 1);
    check("ack_coinc_overrun", 32'(overrun), 0);
    check("ack_coinc_rx_data", 32'(rx_data), 'hA3);
    ack();
    tick(2);

    // tx_load while the buffer is full is ignored
    load(8'h77);
    load(8'h88);
    check("txfull_tx_ready", 32'(tx_ready), 0);
    frame(8'h0F, 0, 8'h77, "txfull");
    check("txfull_rx_data", 32'(rx_data), 'h0F);
    ack();
    tick(2);

    // Asynchronous reset in the middle of a frame
    load(8'h99);
    chk_en = 1'b0;
    ssn = 1'b0;
    void'(model_start());
    mosi = 1'b1;
    tick(4); sclk = 1'b1;
    tick(4); sclk = 1'b0;
    tick(4); sclk = 1'b1;
    tick(2);
    check("midrst_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(miso), 0);
    check("midrst_miso_oe", 32'(miso_oe), 0);
    check("midrst_tx_ready", 32'(tx_ready), 1);
    check("midrst_rx_valid", 32'(rx_valid), 0);
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_busy", 32'(busy), 0);
    model_reset();
    tick(1);
    sclk = 1'b0;
    ssn = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk_en = 1'b1;
    tick(10);

    chk_en = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
